mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Initiator-side load/store sequencer that drives the DataMemory interface (Address, WriteData, MemRead, MemWrite, ReadData) on behalf of the datapath MEM stage.
- Accepts byte, halfword and word load/store requests over a valid/ready handshake.
- Performs read-modify-write for sub-word stores, lane extraction and sign/zero extension for loads, and alignment checking.
- Sequences MemWrite so Address and WriteData are stable for the whole cycle MemWrite is high. DataMemory reads combinationally and writes level-sensitively.

Parameters:
- ADDR_W, 32, byte-address width
- DATA_W, 32, data word width (fixed at 32; lane logic assumes 4 bytes)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- ReqValid  input  1  request present
- ReqReady  output  1  unit can accept a request
- ReqWrite  input  1  1 = store, 0 = load
- ReqSize  input  2  00 byte, 01 half, 10 word, 11 illegal
- ReqSigned  input  1  sign-extend load result
- ReqAddr  input  ADDR_W  byte address
- ReqWData  input  DATA_W  store data (low-aligned)
- RespValid  output  1  one-cycle completion pulse
- RespData  output  DATA_W  load result (0 for stores/errors)
- Misaligned  output  1  error flag, valid with RespValid
- Address  output  ADDR_W  memory word address
- WriteData  output  DATA_W  memory write word
- MemRead  output  1  memory read enable
- MemWrite  output  1  memory write enable
- ReadData  input  DATA_W  memory read word (combinational)

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values: state IDLE; ReqReady=1; RespValid=0; RespData=0; Misaligned=0; Address=0; WriteData=0; MemRead=0; MemWrite=0.
- Reset mid-operation: all outputs clear immediately and asynchronously. MemWrite drops without waiting for a clock edge. Any in-flight request is discarded with no response.
- Handshake: ReqReady=1 only in IDLE. A request is accepted on a rising edge with ReqValid&&ReqReady. All request fields are latched at acceptance.
- Response: RespValid is a single-cycle pulse with no backpressure.
- Address output: {ReqAddr[ADDR_W-1:2],2'b00}, registered and held constant from the first memory-access state through the last.
- Lanes: little-endian. Byte lane = addr[1:0]; halfword lane = addr[1].
- Alignment: half with addr[0]=1, word with addr[1:0]!=0, or ReqSize=11 is an error.
  - Error path: IDLE -> ERR -> IDLE.
  - ERR cycle: RespValid=1, Misaligned=1, RespData=0.
  - No MemRead/MemWrite is asserted.
- States: IDLE, RD, RMW_RD, WR_SETUP, WR, RESP, ERR.
- Load: IDLE -> RD -> RESP.
  - RD: MemRead=1; ReadData is captured at the end of RD.
  - RESP: RespValid=1, RespData = extracted lane. Sign extension if ReqSigned, else zero extension.
  - Latency: RespValid 2 cycles after acceptance.
- Word store: IDLE -> WR_SETUP -> WR -> RESP.
  - WR_SETUP: WriteData=ReqWData, MemWrite=0.
  - WR: MemWrite=1, Address and WriteData unchanged.
  - RESP: MemWrite=0, RespValid=1, RespData=0.
  - Latency: 3 cycles.
- Sub-word store: IDLE -> RMW_RD -> WR_SETUP -> WR -> RESP.
  - RMW_RD: MemRead=1; ReadData is captured.
  - WR_SETUP: WriteData = captured word with the target lane replaced by ReqWData[7:0] or ReqWData[15:0].
  - Latency: 4 cycles.
- Mutual exclusion: MemRead and MemWrite are never high in the same cycle.
- Output timing: MemWrite is a registered output; it is never high in the cycle in which Address or WriteData change.
- RESP/ERR exit: RESP and ERR always return to IDLE. A new request is accepted in the cycle after RESP/ERR at the earliest.
- ReqValid during busy states is ignored. The requester holds it until ReqReady is seen.

Test Plan:
- Word store then load: store addr 0x0, data 0xDEADBEEF.
  - MemWrite high for exactly 1 cycle; RespValid 3 cycles after acceptance.
  - Load addr 0x0, word: RespData=0xDEADBEEF 2 cycles after acceptance.
- Byte store RMW: memory[0]=0xDEADBEEF; store byte 0x55 at addr 0x2.
  - WriteData=0xDE55BEEF during WR; MemRead and MemWrite never overlap; RespValid 4 cycles after acceptance.
- Signed/unsigned loads: memory[1]=0x80F07F01, word address 0x4.
  - Signed byte @0x6 -> 0xFFFFFFF0.
  - Unsigned half @0x6 -> 0x000080F0.
  - Signed half @0x4 -> 0x00007F01.
- Misalignment: word load @0x2, half store @0x5, size=11 @0x0.
  - Each gives RespValid+Misaligned=1 the cycle after acceptance, RespData=0, and no MemRead/MemWrite.
- Back-to-back and busy behaviour: ReqValid held continuously across two loads.
  - ReqReady=0 in RD/RESP; the second request is accepted the cycle after RESP; exactly 2 RespValid pulses.
- Reset mid-store: assert rst_n=0 during WR.
  - MemWrite=0 immediately (before the next clk edge); all outputs reset; no RespValid after release; ReqReady=1.

Source files
------------

// File: rtl/mem_access_unit.sv
// Load/store sequencer driving DataMemory: sub-word RMW, lane extract/extend, alignment check.
// Latency accept->RespValid: error 1, load 2, word store 3, sub-word store 4 cycles.
// ReqReady only in IDLE; RespValid is a one-cycle pulse with no backpressure.
module mem_access_unit #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ReqValid,
    output logic              ReqReady,
    input  logic              ReqWrite,
    input  logic [1:0]        ReqSize,
    input  logic              ReqSigned,
    input  logic [ADDR_W-1:0] ReqAddr,
    input  logic [DATA_W-1:0] ReqWData,
    output logic              RespValid,
    output logic [DATA_W-1:0] RespData,
    output logic              Misaligned,
    output logic [ADDR_W-1:0] Address,
    output logic [DATA_W-1:0] WriteData,
    output logic              MemRead,
    output logic              MemWrite,
    input  logic [DATA_W-1:0] ReadData
);

    typedef enum logic [2:0] {IDLE, RD, RMW_RD, WR_SETUP, WR, RESP, ERR} state_t;

    state_t            state, nextState;
    logic [1:0]        sizeQ;
    logic [1:0]        laneQ;
    logic              signedQ;
    logic [DATA_W-1:0] wdataQ;
    logic              accept;
    logic              reqMisaligned;
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] loadData;
    logic [DATA_W-1:0] mergeData;

    assign accept = (state == IDLE) && ReqValid;

    always_comb begin
        reqMisaligned = 1'b0;
        case (ReqSize)
            2'b00:   reqMisaligned = 1'b0;
            2'b01:   reqMisaligned = ReqAddr[0];
            2'b10:   reqMisaligned = (ReqAddr[1:0] != 2'b00);
            default: reqMisaligned = 1'b1;
        endcase
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (ReqValid) begin
                    if (reqMisaligned)        nextState = ERR;
                    else if (!ReqWrite)       nextState = RD;
                    else if (ReqSize == 2'b10) nextState = WR_SETUP;
                    else                      nextState = RMW_RD;
                end
            end
            RD:       nextState = RESP;
            RMW_RD:   nextState = WR_SETUP;
            WR_SETUP: nextState = WR;
            WR:       nextState = RESP;
            RESP:     nextState = IDLE;
            ERR:      nextState = IDLE;
            default:  nextState = IDLE;
        endcase
    end

    // Lane extraction: aligned requests guarantee the shifted lane sits in the low bits.
    always_comb begin
        shifted  = ReadData >> {laneQ, 3'b000};
        loadData = ReadData;
        case (sizeQ)
            2'b00:   loadData = {{24{signedQ & shifted[7]}}, shifted[7:0]};
            2'b01:   loadData = {{16{signedQ & shifted[15]}}, shifted[15:0]};
            default: loadData = ReadData;
        endcase
    end

    always_comb begin
        mergeData = ReadData;
        if (sizeQ == 2'b00)
            mergeData[{laneQ, 3'b000} +: 8] = wdataQ[7:0];
        else
            mergeData[{laneQ[1], 4'b0000} +: 16] = wdataQ[15:0];
    end

    // Outputs are registered from nextState so MemWrite only rises after Address/WriteData settled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ReqReady   <= 1'b1;
            RespValid  <= 1'b0;
            RespData   <= '0;
            Misaligned <= 1'b0;
            Address    <= '0;
            WriteData  <= '0;
            MemRead    <= 1'b0;
            MemWrite   <= 1'b0;
            sizeQ      <= 2'b00;
            laneQ      <= 2'b00;
            signedQ    <= 1'b0;
            wdataQ     <= '0;
        end else begin
            state      <= nextState;
            ReqReady   <= (nextState == IDLE);
            RespValid  <= (nextState == RESP) || (nextState == ERR);
            Misaligned <= (nextState == ERR);
            MemRead    <= (nextState == RD) || (nextState == RMW_RD);
            MemWrite   <= (nextState == WR);
            RespData   <= (state == RD) ? loadData : '0;
            if (accept) begin
                Address <= {ReqAddr[ADDR_W-1:2], 2'b00};
                sizeQ   <= ReqSize;
                laneQ   <= ReqAddr[1:0];
                signedQ <= ReqSigned;
                wdataQ  <= ReqWData;
            end
            if (nextState == WR_SETUP)
                WriteData <= (state == IDLE) ? ReqWData : mergeData;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed vector table, hand-written busy/reset sequences,
// and randomized requests checked against a byte-array reference model.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        ReqValid = 1'b0;
    logic        ReqReady;
    logic        ReqWrite = 1'b0;
    logic [1:0]  ReqSize = 2'b00;
    logic        ReqSigned = 1'b0;
    logic [31:0] ReqAddr = '0;
    logic [31:0] ReqWData = '0;
    logic        RespValid;
    logic [31:0] RespData;
    logic        Misaligned;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] ReadData;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqWrite(ReqWrite),
        .ReqSize(ReqSize), .ReqSigned(ReqSigned), .ReqAddr(ReqAddr), .ReqWData(ReqWData),
        .RespValid(RespValid), .RespData(RespData), .Misaligned(Misaligned),
        .Address(Address), .WriteData(WriteData), .MemRead(MemRead), .MemWrite(MemWrite),
        .ReadData(ReadData)
    );

    // Memory seen by the DUT, and the model's independent byte view of it.
    logic [31:0] simMem[16] = '{default: '0};
    logic [7:0]  refMem[64] = '{default: '0};

    assign ReadData = simMem[Address[5:2]];
    always @(negedge clk) if (MemWrite) simMem[Address[5:2]] = WriteData;

    int          nChecks = 0;
    int          nFails = 0;
    int          rdCnt = 0, wrCnt = 0, ovlCnt = 0, stabErr = 0;
    logic [31:0] prevAddr = '0, prevWd = '0, wrWord = '0;

    always @(negedge clk) begin
        if (MemRead) rdCnt++;
        if (MemWrite) begin
            wrCnt++;
            wrWord = WriteData;
            if (Address !== prevAddr || WriteData !== prevWd) stabErr++;
        end
        if (MemRead && MemWrite) ovlCnt++;
        prevAddr = Address;
        prevWd   = WriteData;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] refWord(input int wa);
        return {refMem[wa*4+3], refMem[wa*4+2], refMem[wa*4+1], refMem[wa*4]};
    endfunction

    // Reference model: byte-addressed memory, arithmetic alignment and sign extension.
    function automatic void model(input logic wr, input logic [1:0] sz, input logic sgn,
                                  input int addr, input logic [31:0] wd,
                                  output logic [31:0] eData, output logic eMis,
                                  output int eLat, output int eRd, output int eWr);
        int nb;
        nb    = 1 << sz;
        eMis  = (sz == 2'd3) || ((addr % nb) != 0);
        eData = '0;
        eRd   = 0;
        eWr   = 0;
        if (eMis) begin
            eLat = 1;
        end else if (!wr) begin
            for (int i = 0; i < nb; i++) eData = eData | (32'(refMem[addr+i]) << (8*i));
            if (sgn && nb < 4 && eData[8*nb-1]) eData = eData - (32'd1 << (8*nb));
            eLat = 2;
            eRd  = 1;
        end else begin
            for (int i = 0; i < nb; i++) refMem[addr+i] = wd[8*i +: 8];
            eLat = (nb == 4) ? 3 : 4;
            eRd  = (nb == 4) ? 0 : 1;
            eWr  = 1;
        end
    endfunction

    task automatic waitReady();
        int k;
        k = 0;
        @(negedge clk);
        while (!ReqReady && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("req_ready_wait", {31'd0, ReqReady}, 32'd1);
    endtask

    task automatic runReq(input logic wr, input logic [1:0] sz, input logic sgn,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output int lat, output logic [31:0] data, output logic mis,
                          output int nRd, output int nWr);
        int r0, w0;
        waitReady();
        ReqWrite = wr; ReqSize = sz; ReqSigned = sgn; ReqAddr = addr; ReqWData = wd;
        ReqValid = 1'b1;
        r0 = rdCnt; w0 = wrCnt;
        @(posedge clk);
        #1 ReqValid = 1'b0;
        lat = 0; data = 'x; mis = 1'bx;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (RespValid) begin
                lat = k; data = RespData; mis = Misaligned;
                break;
            end
        end
        nRd = rdCnt - r0;
        nWr = wrCnt - w0;
    endtask

    typedef struct {
        logic        wr;
        logic [1:0]  sz;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] expData;
        logic        expMis;
        int          expLat;
        logic [31:0] expMem;
    } vec_t;

    vec_t vecs[12];

    initial begin
        int          lat, nRd, nWr, eLat, eRd, eWr, acc, resps, busy;
        logic [31:0] data, eData;
        logic        mis, eMis;
        int          accCyc[2];
        int          respCyc[2];
        logic [31:0] respDat[2];

        vecs[0]  = '{1'b1, 2'd2, 1'b0, 32'h0, 32'hDEADBEEF, 32'h0,        1'b0, 3, 32'hDEADBEEF};
        vecs[1]  = '{1'b0, 2'd2, 1'b0, 32'h0, 32'h0,        32'hDEADBEEF, 1'b0, 2, 32'hDEADBEEF};
        vecs[2]  = '{1'b1, 2'd0, 1'b0, 32'h2, 32'hAAAAAA55, 32'h0,        1'b0, 4, 32'hDE55BEEF};
        vecs[3]  = '{1'b1, 2'd2, 1'b0, 32'h4, 32'h80F07F01, 32'h0,        1'b0, 3, 32'h80F07F01};
        vecs[4]  = '{1'b0, 2'd0, 1'b1, 32'h6, 32'h0,        32'hFFFFFFF0, 1'b0, 2, 32'h80F07F01};
        vecs[5]  = '{1'b0, 2'd1, 1'b0, 32'h6, 32'h0,        32'h000080F0, 1'b0, 2, 32'h80F07F01};
        vecs[6]  = '{1'b0, 2'd1, 1'b1, 32'h4, 32'h0,        32'h00007F01, 1'b0, 2, 32'h80F07F01};
        vecs[7]  = '{1'b0, 2'd2, 1'b0, 32'h2, 32'h0,        32'h0,        1'b1, 1, 32'hDE55BEEF};
        vecs[8]  = '{1'b1, 2'd1, 1'b0, 32'h5, 32'hFFFF,     32'h0,        1'b1, 1, 32'h80F07F01};
        vecs[9]  = '{1'b0, 2'd3, 1'b0, 32'h0, 32'h0,        32'h0,        1'b1, 1, 32'hDE55BEEF};
        vecs[10] = '{1'b0, 2'd0, 1'b0, 32'h3, 32'h0,        32'h000000DE, 1'b0, 2, 32'hDE55BEEF};
        vecs[11] = '{1'b0, 2'd0, 1'b1, 32'h1, 32'h0,        32'hFFFFFFBE, 1'b0, 2, 32'hDE55BEEF};

        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ReqReady",   {31'd0, ReqReady},   32'd1);
        chk("rst_RespValid",  {31'd0, RespValid},  32'd0);
        chk("rst_RespData",   RespData,            32'd0);
        chk("rst_Misaligned", {31'd0, Misaligned}, 32'd0);
        chk("rst_Address",    Address,             32'd0);
        chk("rst_WriteData",  WriteData,           32'd0);
        chk("rst_MemRead",    {31'd0, MemRead},    32'd0);
        chk("rst_MemWrite",   {31'd0, MemWrite},   32'd0);
        rst_n = 1'b1;

        for (int v = 0; v < 12; v++) begin
            model(vecs[v].wr, vecs[v].sz, vecs[v].sgn, int'(vecs[v].addr), vecs[v].wdata,
                  eData, eMis, eLat, eRd, eWr);
            runReq(vecs[v].wr, vecs[v].sz, vecs[v].sgn, vecs[v].addr, vecs[v].wdata,
                   lat, data, mis, nRd, nWr);
            chk($sformatf("vec%0d_latency", v), lat, vecs[v].expLat);
            chk($sformatf("vec%0d_RespData", v), data, vecs[v].expData);
            chk($sformatf("vec%0d_Misaligned", v), {31'd0, mis}, {31'd0, vecs[v].expMis});
            chk($sformatf("vec%0d_mem", v), simMem[vecs[v].addr[5:2]], vecs[v].expMem);
            chk($sformatf("vec%0d_reads", v), nRd, eRd);
            chk($sformatf("vec%0d_writes", v), nWr, eWr);
            if (vecs[v].wr && !vecs[v].expMis)
                chk($sformatf("vec%0d_WriteData", v), wrWord, vecs[v].expMem);
        end

        // ReqValid held across two loads: second accept only after RESP.
        waitReady();
        ReqWrite = 1'b0; ReqSize = 2'd2; ReqSigned = 1'b0; ReqAddr = 32'h0; ReqValid = 1'b1;
        acc = 0; resps = 0; busy = 0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (ReqValid && !ReqReady) busy++;
            if (RespValid && resps < 2) begin
                respCyc[resps] = c; respDat[resps] = RespData;
            end
            if (RespValid) resps++;
            if (ReqValid && ReqReady) begin
                if (acc < 2) accCyc[acc] = c;
                acc++;
            end
            @(posedge clk);
            #1;
            if (acc == 1) ReqAddr = 32'h4;
            if (acc >= 2) ReqValid = 1'b0;
            @(negedge clk);
        end
        chk("b2b_accepts", acc, 2);
        chk("b2b_resp_pulses", resps, 2);
        chk("b2b_busy_not_ready", busy, 2);
        chk("b2b_second_accept_cycle", accCyc[1] - accCyc[0], 3);
        chk("b2b_resp0_latency", respCyc[0] - accCyc[0], 2);
        chk("b2b_resp0_data", respDat[0], 32'hDE55BEEF);
        chk("b2b_resp1_data", respDat[1], 32'h80F07F01);

        // Randomized traffic over words 0..14 against the byte model.
        for (int n = 0; n < 80; n++) begin
            logic        wr, sgn;
            logic [1:0]  sz;
            int          r, addr;
            logic [31:0] wd;
            wr   = 1'($urandom_range(0, 1));
            sgn  = 1'($urandom_range(0, 1));
            r    = $urandom_range(0, 9);
            sz   = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
            addr = $urandom_range(0, 59);
            wd   = $urandom;
            model(wr, sz, sgn, addr, wd, eData, eMis, eLat, eRd, eWr);
            runReq(wr, sz, sgn, 32'(addr), wd, lat, data, mis, nRd, nWr);
            chk("rnd_latency", lat, eLat);
            chk("rnd_RespData", data, eData);
            chk("rnd_Misaligned", {31'd0, mis}, {31'd0, eMis});
            chk("rnd_reads", nRd, eRd);
            chk("rnd_writes", nWr, eWr);
            chk("rnd_mem", simMem[addr/4], refWord(addr/4));
            if (eWr == 1) chk("rnd_WriteData", wrWord, refWord(addr/4));
        end

        // Reset asserted while MemWrite is high: everything clears before the next edge.
        waitReady();
        ReqWrite = 1'b1; ReqSize = 2'd2; ReqSigned = 1'b0; ReqAddr = 32'h3C;
        ReqWData = 32'h12345678; ReqValid = 1'b1;
        @(posedge clk);
        #1 ReqValid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (MemWrite) break;
        end
        chk("rst_mid_reached_WR", {31'd0, MemWrite}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_MemWrite",   {31'd0, MemWrite},   32'd0);
        chk("rst_mid_MemRead",    {31'd0, MemRead},    32'd0);
        chk("rst_mid_RespValid",  {31'd0, RespValid},  32'd0);
        chk("rst_mid_ReqReady",   {31'd0, ReqReady},   32'd1);
        chk("rst_mid_Address",    Address,             32'd0);
        chk("rst_mid_WriteData",  WriteData,           32'd0);
        chk("rst_mid_RespData",   RespData,            32'd0);
        chk("rst_mid_Misaligned", {31'd0, Misaligned}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        resps = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (RespValid) resps++;
        end
        chk("rst_mid_no_resp", resps, 0);
        chk("rst_mid_ready_after", {31'd0, ReqReady}, 32'd1);

        chk("mem_rd_wr_overlap", ovlCnt, 0);
        chk("memwrite_addr_data_stable", stabErr, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, %0d checks so far", nChecks);
        $fatal(1, "timeout");
    end

endmodule
